// File: rtl/regbank_arbiter_if.sv
// Request/response port bundle for one requester of the shared register bank.
// Requester drives the request fields and resp_rdy; the bank drives the rest.
// All handshakes are val/rdy; a transfer happens when both are high at an edge.
interface regbank_arbiter_if #(
  parameter int unsigned NBITS = 8,
  parameter int unsigned AW    = 2
);
  logic             req_val;
  logic             req_rdy;
  logic             req_wen;
  logic [AW-1:0]    req_addr;
  logic [NBITS-1:0] req_wdata;
  logic             resp_val;
  logic             resp_rdy;
  logic [NBITS-1:0] resp_rdata;

  // Requester side
  modport master (
    output req_val, req_wen, req_addr, req_wdata, resp_rdy,
    input  req_rdy, resp_val, resp_rdata
  );

  // Bank/arbiter side
  modport slave (
    input  req_val, req_wen, req_addr, req_wdata, resp_rdy,
    output req_rdy, resp_val, resp_rdata
  );
endinterface

// File: rtl/regbank_arbiter.sv
// Two-port round-robin arbiter in front of a small flip-flop register bank.
// Latency: 1 cycle from request fire to registered response valid.
// Backpressure: a port whose response is stalled gets no grant; the other port is unaffected.
module regbank_arbiter #(
  parameter int unsigned NBITS = 8,
  parameter int unsigned NREGS = 4,
  parameter int unsigned AW    = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  regbank_arbiter_if.slave     p0,
  regbank_arbiter_if.slave     p1
);

  // Per-port views of the two interfaces, indexed by port number
  logic [1:0]       req_val;
  logic [1:0]       req_wen;
  logic [1:0]       resp_rdy;
  logic [AW-1:0]    req_addr  [2];
  logic [NBITS-1:0] req_wdata [2];

  // Arbitration terms
  logic [1:0]       free;
  logic [1:0]       elig;
  logic [1:0]       rdy;
  logic [1:0]       fire;

  // The single access selected this cycle
  logic             acc_go;
  logic             acc_port;
  logic             acc_wen;
  logic [AW-1:0]    acc_addr;
  logic [NBITS-1:0] acc_wdata;
  logic [NBITS-1:0] acc_rdata;

  // State
  logic [NBITS-1:0] bank_q       [NREGS];
  logic [1:0]       resp_val_q;
  logic [NBITS-1:0] resp_rdata_q [2];
  logic             ptr_q;

  assign req_val      = {p1.req_val,  p0.req_val};
  assign req_wen      = {p1.req_wen,  p0.req_wen};
  assign resp_rdy     = {p1.resp_rdy, p0.resp_rdy};
  assign req_addr[0]  = p0.req_addr;
  assign req_addr[1]  = p1.req_addr;
  assign req_wdata[0] = p0.req_wdata;
  assign req_wdata[1] = p1.req_wdata;

  assign p0.req_rdy    = rdy[0];
  assign p1.req_rdy    = rdy[1];
  assign p0.resp_val   = resp_val_q[0];
  assign p1.resp_val   = resp_val_q[1];
  assign p0.resp_rdata = resp_rdata_q[0];
  assign p1.resp_rdata = resp_rdata_q[1];

  // Grant: a port is ready when its response slot frees up and it either has
  // no competitor or holds priority. rdy never looks at the port's own val, so
  // at most one port can fire per cycle.
  always_comb begin
    free = '0;
    elig = '0;
    rdy  = '0;
    for (int n = 0; n < 2; n++) begin
      free[n] = !resp_val_q[n] || resp_rdy[n];
      elig[n] = req_val[n] && free[n];
    end
    rdy[0] = reset_n && free[0] && (!elig[1] || (ptr_q == 1'b0));
    rdy[1] = reset_n && free[1] && (!elig[0] || (ptr_q == 1'b1));
    fire   = req_val & rdy;
  end

  // Mux the winning port's request onto the shared bank access path
  always_comb begin
    acc_go    = |fire;
    acc_port  = fire[1];
    acc_wen   = req_wen[acc_port];
    acc_addr  = req_addr[acc_port];
    acc_wdata = req_wdata[acc_port];
    acc_rdata = bank_q[acc_addr];
  end

  // Register bank: cleared on reset, written by the granted write access
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        bank_q[i] <= '0;
      end
    end else if (acc_go && acc_wen) begin
      bank_q[acc_addr] <= acc_wdata;
    end
  end

  // Response registers: load on fire (write echoes data, read returns the
  // pre-edge bank value), otherwise drain when the consumer accepts
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      resp_val_q      <= '0;
      resp_rdata_q[0] <= '0;
      resp_rdata_q[1] <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (fire[n]) begin
          resp_val_q[n]   <= 1'b1;
          resp_rdata_q[n] <= acc_wen ? acc_wdata : acc_rdata;
        end else if (resp_rdy[n]) begin
          resp_val_q[n]   <= 1'b0;
        end
      end
    end
  end

  // Priority pointer: moves to the losing port only when both were eligible
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q <= 1'b0;
    end else if (&elig) begin
      ptr_q <= ~ptr_q;
    end
  end

endmodule

// File: tb/tb_regbank_arbiter.sv
// Directed bench for regbank_arbiter: reset, single-port access, round-robin,
// response backpressure, cross-port read-after-write and mid-operation reset.
module tb_regbank_arbiter;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  int   r0cnt;
  int   r1cnt;

  regbank_arbiter_if #(.NBITS(8), .AW(2)) p0_if ();
  regbank_arbiter_if #(.NBITS(8), .AW(2)) p1_if ();

  regbank_arbiter #(.NBITS(8), .NREGS(4), .AW(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .p0      (p0_if),
    .p1      (p1_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic val, input logic wen, input logic [1:0] addr, input logic [7:0] wdata);
    p0_if.req_val   = val;
    p0_if.req_wen   = wen;
    p0_if.req_addr  = addr;
    p0_if.req_wdata = wdata;
  endtask

  task automatic drive1(input logic val, input logic wen, input logic [1:0] addr, input logic [7:0] wdata);
    p1_if.req_val   = val;
    p1_if.req_wen   = wen;
    p1_if.req_addr  = addr;
    p1_if.req_wdata = wdata;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset held two cycles with both ports requesting writes
    reset_n = 1'b0;
    p0_if.resp_rdy = 1'b1;
    p1_if.resp_rdy = 1'b1;
    drive0(1'b1, 1'b1, 2'd0, 8'hFF);
    drive1(1'b1, 1'b1, 2'd0, 8'hFF);
    tick();
    tick();
    check("rst_rdy0", p0_if.req_rdy, 0);
    check("rst_rdy1", p1_if.req_rdy, 0);
    check("rst_resp0_val", p0_if.resp_val, 0);
    check("rst_resp1_val", p1_if.resp_val, 0);
    check("rst_resp0_rdata", p0_if.resp_rdata, 0);
    check("rst_resp1_rdata", p1_if.resp_rdata, 0);

    // Leave reset with both ports idle: both see rdy
    reset_n = 1'b1;
    drive0(1'b0, 1'b0, 2'd0, 8'h00);
    drive1(1'b0, 1'b0, 2'd0, 8'h00);
    #1;
    check("idle_rdy0", p0_if.req_rdy, 1);
    check("idle_rdy1", p1_if.req_rdy, 1);

    // Every address reads back zero after reset, one read per cycle
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, 1'b0, 2'(i), 8'h00);
      tick();
      check("rst_read_val", p0_if.resp_val, 1);
      check("rst_read_data", p0_if.resp_rdata, 0);
    end
    drive0(1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    check("drain_resp0_val", p0_if.resp_val, 0);

    // Single-port write then read back, then an untouched address
    drive0(1'b1, 1'b1, 2'd2, 8'hA5);
    tick();
    check("wr_ack_val", p0_if.resp_val, 1);
    check("wr_ack_data", p0_if.resp_rdata, 8'hA5);
    drive0(1'b1, 1'b0, 2'd2, 8'h00);
    tick();
    check("rd2_data", p0_if.resp_rdata, 8'hA5);
    drive0(1'b1, 1'b0, 2'd1, 8'h00);
    tick();
    check("rd1_data", p0_if.resp_rdata, 8'h00);
    drive0(1'b0, 1'b0, 2'd0, 8'h00);
    tick();

    // Contention: grants alternate 0,1,0,1 starting from ptr=0
    r0cnt = 0;
    r1cnt = 0;
    drive0(1'b1, 1'b0, 2'd0, 8'h00);
    drive1(1'b1, 1'b0, 2'd0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_rdy0", p0_if.req_rdy, (i % 2 == 0) ? 1 : 0);
      check("rr_rdy1", p1_if.req_rdy, (i % 2 == 0) ? 0 : 1);
      tick();
      r0cnt += int'(p0_if.resp_val);
      r1cnt += int'(p1_if.resp_val);
    end
    check("rr_count0", r0cnt, 2);
    check("rr_count1", r1cnt, 2);

    // Contested cycle won by port0 moves ptr to port1
    drive1(1'b1, 1'b1, 2'd1, 8'h3C);
    #1;
    check("bp_setup_rdy0", p0_if.req_rdy, 1);
    check("bp_setup_rdy1", p1_if.req_rdy, 0);
    tick();

    // Port1 writes 0x3C alone, then stalls its response
    drive0(1'b0, 1'b0, 2'd0, 8'h00);
    p1_if.resp_rdy = 1'b0;
    #1;
    check("bp_wr_rdy1", p1_if.req_rdy, 1);
    tick();
    check("bp_pend_val", p1_if.resp_val, 1);
    check("bp_pend_data", p1_if.resp_rdata, 8'h3C);

    // Port0 keeps firing reads of addr1 while port1 is stalled
    drive0(1'b1, 1'b0, 2'd1, 8'h00);
    drive1(1'b1, 1'b0, 2'd3, 8'h00);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_rdy0", p0_if.req_rdy, 1);
      check("bp_rdy1", p1_if.req_rdy, 0);
      tick();
      check("bp_hold_val1", p1_if.resp_val, 1);
      check("bp_hold_data1", p1_if.resp_rdata, 8'h3C);
      check("bp_resp0_val", p0_if.resp_val, 1);
      check("bp_resp0_data", p0_if.resp_rdata, 8'h3C);
    end

    // Release: port1 holds priority and is granted in the same cycle
    p1_if.resp_rdy = 1'b1;
    #1;
    check("rel_rdy1", p1_if.req_rdy, 1);
    check("rel_rdy0", p0_if.req_rdy, 0);
    tick();
    check("rel_resp1_val", p1_if.resp_val, 1);
    check("rel_resp1_data", p1_if.resp_rdata, 8'h00);
    check("rel_resp0_val", p0_if.resp_val, 0);

    // Cross-port read-after-write on consecutive edges
    drive0(1'b0, 1'b0, 2'd0, 8'h00);
    drive1(1'b1, 1'b1, 2'd3, 8'h7E);
    #1;
    check("raw_rdy1", p1_if.req_rdy, 1);
    tick();
    check("raw_wr_ack", p1_if.resp_rdata, 8'h7E);
    drive1(1'b0, 1'b0, 2'd0, 8'h00);
    drive0(1'b1, 1'b0, 2'd3, 8'h00);
    tick();
    check("raw_rd_val", p0_if.resp_val, 1);
    check("raw_rd_data", p0_if.resp_rdata, 8'h7E);

    // Contested write of 0x55 to addr1 by port0 leaves ptr at port1
    drive0(1'b1, 1'b1, 2'd1, 8'h55);
    drive1(1'b1, 1'b0, 2'd0, 8'h00);
    #1;
    check("pre_rst_rdy0", p0_if.req_rdy, 1);
    tick();
    check("pre_rst_val0", p0_if.resp_val, 1);
    check("pre_rst_data0", p0_if.resp_rdata, 8'h55);

    // Mid-operation reset with a write presented: nothing fires
    reset_n = 1'b0;
    drive0(1'b1, 1'b1, 2'd1, 8'hAA);
    #1;
    check("mrst_rdy0", p0_if.req_rdy, 0);
    check("mrst_rdy1", p1_if.req_rdy, 0);
    tick();
    check("mrst_resp0_val", p0_if.resp_val, 0);
    check("mrst_resp0_data", p0_if.resp_rdata, 0);
    check("mrst_resp1_val", p1_if.resp_val, 0);

    // After reset ptr is back at port0 and addr1 reads zero
    reset_n = 1'b1;
    drive0(1'b1, 1'b0, 2'd1, 8'h00);
    drive1(1'b1, 1'b0, 2'd1, 8'h00);
    #1;
    check("post_rst_rdy0", p0_if.req_rdy, 1);
    check("post_rst_rdy1", p1_if.req_rdy, 0);
    tick();
    check("post_rst_val0", p0_if.resp_val, 1);
    check("post_rst_data0", p0_if.resp_rdata, 8'h00);
    drive0(1'b0, 1'b0, 2'd0, 8'h00);
    #1;
    check("post_rst_rdy1b", p1_if.req_rdy, 1);
    tick();
    check("post_rst_val1", p1_if.resp_val, 1);
    check("post_rst_data1", p1_if.resp_rdata, 8'h00);
    drive1(1'b0, 1'b0, 2'd0, 8'h00);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
